// File: rtl/usr_pkg.sv
// Mode encodings and field width shared by the universal shift register files.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASHR = 3'b110;

endpackage

// File: rtl/usr_sat_cnt.sv
// Saturating up-counter with synchronous clear; one-edge update, no backpressure.
// Reset and clear both return the count to zero; reset takes precedence.
module usr_sat_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/load/rotate/ashr, one-edge latency, no backpressure.
// Rotate modes exist only when USR_ROTATE_EN is defined; otherwise they hold.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [MODE_W-1:0]          mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin_l,
  input  logic                       sin_r,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_nxt;
  logic             is_shift;
  logic             is_load;

  always_comb begin
    q_nxt    = q;
    is_shift = 1'b0;
    is_load  = 1'b0;
    case (mode)
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin_l};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_nxt    = {sin_r, q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_nxt   = d;
        is_load = 1'b1;
      end
`ifdef USR_ROTATE_EN
      MODE_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
`endif
      MODE_ASHR: begin
        q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= q_nxt;
    end
  end

  usr_sat_cnt #(
    .MAX (WIDTH),
    .W   (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (en & is_load),
    .inc   (en & is_shift),
    .cnt   (shift_cnt)
  );

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign sout_l  = q[WIDTH-1];
  assign sout_r  = q[0];
  assign drained = (shift_cnt == CW'(WIDTH));

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8, RESET_VAL=0.
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] shift_cnt;
  logic       drained;

  int checks   = 0;
  int failures = 0;

  universal_shift_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
    .drained   (drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one operation and sample 1 time unit after the edge that executes it.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dd, input logic sl, input logic sr);
    reset = r; en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic [3:0] ec);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_cnt"}, 32'(shift_cnt), 32'(ec));
    chk({tag, "_drained"}, 32'(drained), 32'(ec == 4'd8));
    chk({tag, "_sout_l"}, 32'(sout_l), 32'(eq[7]));
    chk({tag, "_sout_r"}, 32'(sout_r), 32'(eq[0]));
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;
    #2;

    // Reset overrides a pending load.
    step(1, 1, MODE_LOAD, 8'hFF, 0, 0);
    step(1, 1, MODE_LOAD, 8'hFF, 0, 0);
    chk_state("reset", 8'h00, 4'd0);

    // Load then eight left shifts drain the register.
    step(0, 1, MODE_LOAD, 8'hA5, 0, 0);
    chk_state("load_a5", 8'hA5, 4'd0);
    step(0, 1, MODE_SHL, 8'h00, 0, 0);
    chk_state("shl1", 8'h4A, 4'd1);
    for (int i = 0; i < 7; i++) step(0, 1, MODE_SHL, 8'h00, 0, 0);
    chk_state("shl8", 8'h00, 4'd8);
    step(0, 1, MODE_SHL, 8'h00, 1, 0);
    chk_state("shl9_sat", 8'h01, 4'd8);

    // Arithmetic then logical right shift.
    step(0, 1, MODE_LOAD, 8'h90, 0, 0);
    step(0, 1, MODE_ASHR, 8'h00, 0, 0);
    chk_state("ashr1", 8'hC8, 4'd1);
    step(0, 1, MODE_ASHR, 8'h00, 0, 0);
    chk_state("ashr2", 8'hE4, 4'd2);
    step(0, 1, MODE_SHR, 8'h00, 0, 0);
    chk_state("shr1", 8'h72, 4'd3);

    // Enable low freezes everything, including a pending load.
    step(0, 1, MODE_LOAD, 8'h3C, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, MODE_SHL, 8'h00, 1, 1);
    chk_state("en_low", 8'h3C, 4'd0);
    step(0, 1, MODE_SHL, 8'h00, 1, 0);
    chk_state("en_shl", 8'h79, 4'd1);
    step(0, 0, MODE_LOAD, 8'h00, 0, 0);
    chk_state("en_low_load", 8'h79, 4'd1);

    // Hold and reserved encodings.
    step(0, 1, MODE_HOLD, 8'hFF, 1, 1);
    chk_state("hold", 8'h79, 4'd1);
    step(0, 1, 3'b111, 8'hFF, 1, 1);
    chk_state("reserved", 8'h79, 4'd1);

    // Rotates never touch the shift count.
    step(0, 1, MODE_LOAD, 8'h81, 0, 0);
`ifdef USR_ROTATE_EN
    step(0, 1, MODE_ROTL, 8'h00, 0, 0);
    chk_state("rotl", 8'h03, 4'd0);
    step(0, 1, MODE_ROTR, 8'h00, 0, 0);
    chk_state("rotr1", 8'h81, 4'd0);
    step(0, 1, MODE_ROTR, 8'h00, 0, 0);
    chk_state("rotr2", 8'hC0, 4'd0);
`else
    step(0, 1, MODE_ROTL, 8'h00, 1, 1);
    chk_state("rotl_off", 8'h81, 4'd0);
    step(0, 1, MODE_ROTR, 8'h00, 1, 1);
    step(0, 1, MODE_ROTR, 8'h00, 1, 1);
    chk_state("rotr_off", 8'h81, 4'd0);
`endif

    // Reset mid-sequence, then the very next edge executes its mode.
    step(0, 1, MODE_LOAD, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, MODE_SHL, 8'h00, 0, 0);
    chk_state("mid_shl3", 8'hF8, 4'd3);
    step(1, 1, MODE_SHL, 8'h00, 1, 1);
    chk_state("mid_reset", 8'h00, 4'd0);
    step(0, 1, MODE_SHR, 8'h00, 0, 1);
    chk_state("post_reset_shr", 8'h80, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, 0, value loaded into q on reset.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- en, input, 1, operation enable; 0 = hold all state.
- mode, input, 3, operation select (encoding per REQ-006).
- d, input, WIDTH, parallel load data.
- sin_l, input, 1, serial-in bit for left shift (enters bit 0).
- sin_r, input, 1, serial-in bit for right shift (enters bit WIDTH-1).
- q, output, WIDTH, register contents.
- sout_l, output, 1, equals q[WIDTH-1].
- sout_r, output, 1, equals q[0].
- shift_cnt, output, $clog2(WIDTH+1), number of shifts since the last load or reset.
- drained, output, 1, high when shift_cnt == WIDTH.

REQ-003 The design SHALL have one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 q and shift_cnt SHALL be registers; sout_l, sout_r and drained SHALL be combinational from those registers only (no input-to-output path).
REQ-005 When en=0, q and shift_cnt SHALL hold, regardless of mode.
REQ-006 When en=1, the mode encodings SHALL act as follows on the next edge:
- 000 hold.
- 001 shl: q <= {q[WIDTH-2:0], sin_l}.
- 010 shr: q <= {sin_r, q[WIDTH-1:1]}.
- 011 load: q <= d.
- 100 rotl.
- 101 rotr.
- 110 ashr: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- 111 reserved, behaves as hold.
REQ-007 shl, shr and ashr SHALL increment shift_cnt, saturating at WIDTH; load SHALL clear shift_cnt to 0; hold, rotate and reserved modes SHALL leave shift_cnt unchanged.
REQ-008 Latency SHALL be exactly one clk edge from inputs to q, with no internal pipelining.
REQ-009 At saturation (shift_cnt == WIDTH), further shifts SHALL still update q while shift_cnt stays at WIDTH and drained stays 1.

Reset
REQ-010 On a rising edge with reset=1, q SHALL become RESET_VAL and shift_cnt SHALL become 0, overriding en and mode.
REQ-011 Reset asserted in the middle of a shift sequence SHALL discard that sequence; the first edge after reset deasserts SHALL execute the mode presented at that edge.
REQ-012 After reset, sout_l SHALL equal RESET_VAL[WIDTH-1], sout_r SHALL equal RESET_VAL[0], and drained SHALL be 0.

Configuration
REQ-013 Macro USR_ROTATE_EN SHALL gate rotate support.
- Defined: mode 100 SHALL perform q <= {q[WIDTH-2:0], q[WIDTH-1]}; mode 101 SHALL perform q <= {q[0], q[WIDTH-1:1]}.
- Undefined: modes 100 and 101 SHALL behave as hold.

Structure
REQ-014 Package usr_pkg SHALL hold:
- the mode encoding constants (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_ASHR);
- the mode field width constant (3).
REQ-015 The saturating shift counter SHALL be a sub-module, usr_sat_cnt (parameters MAX and width; inputs clear and inc).

Verification (WIDTH=8, RESET_VAL=0)
REQ-016 The bench SHALL cover these directed scenarios:
- Reset: reset=1 for 2 edges with mode=011, d=8'hFF -> q=8'h00, shift_cnt=0, drained=0.
- Load then shift left: load 8'hA5, then 8 shl edges with sin_l=0 -> q=8'h00, shift_cnt=8, drained=1; a 9th shl keeps shift_cnt=8.
- Arithmetic shift right: load 8'h90, ashr x2 -> q=8'hE4, shift_cnt=2; shr x1 with sin_r=0 -> q=8'h72, shift_cnt=3.
- Enable low: load 8'h3C, then en=0 with mode=001 for 5 edges -> q=8'h3C, shift_cnt=0.
- Rotate, macro defined: load 8'h81, rotl -> q=8'h03; rotr x2 -> q=8'hC0; shift_cnt=0 throughout. Macro undefined: q stays 8'h81.
- Mid-sequence reset: load 8'hFF, shl x3, assert reset for 1 edge -> q=8'h00, shift_cnt=0; next edge with shr and sin_r=1 -> q=8'h80, shift_cnt=1.
